// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one RAM port between IFU and LSU,
//            with a response timeout and post-abort drain.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_reqValid,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wbmask,
    input  logic [31:0] lsu_addr,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_reqValid,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wbmask,
    output logic [31:0] mem_addr,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_RESP  = 3'd3;
    localparam logic [2:0] c_ST_DRAIN = 3'd4;

    localparam logic c_OWN_IFU = 1'b0;
    localparam logic c_OWN_LSU = 1'b1;

    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic            r_last_grant;
    logic            r_owner;
    logic            r_abort;
    logic [TO_W-1:0] r_cnt;
    logic [31:0]     r_mem_addr;
    logic            r_mem_wen;
    logic [31:0]     r_mem_wdata;
    logic [3:0]      r_mem_wbmask;
    logic [31:0]     r_ifu_rdata;
    logic            r_ifu_err;
    logic [31:0]     r_lsu_rdata;
    logic            r_lsu_err;

    logic            w_grant_any;
    logic            w_grant_lsu;
    logic            w_wait_done;
    logic            w_resp_err;
    logic [31:0]     w_resp_data;

    // On a tie the LSU wins only if the IFU held the previous grant.
    always_comb begin
        w_grant_any  = ifu_reqValid || lsu_reqValid;
        w_grant_lsu  = lsu_reqValid && (!ifu_reqValid || (r_last_grant == c_OWN_IFU));
        w_wait_done  = mem_respValid || (r_cnt == c_TO_LAST);
        w_resp_err   = !mem_respValid;
        w_resp_data  = mem_respValid ? mem_rdata : 32'd0;
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_grant_any) w_next_state = c_ST_ISSUE;
            c_ST_ISSUE: w_next_state = c_ST_WAIT;
            c_ST_WAIT:  if (w_wait_done) w_next_state = c_ST_RESP;
            c_ST_RESP:  w_next_state = r_abort ? c_ST_DRAIN : c_ST_IDLE;
            c_ST_DRAIN: if (mem_respValid) w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_last_grant <= c_OWN_LSU;
            r_owner      <= c_OWN_IFU;
            r_abort      <= 1'b0;
            r_cnt        <= '0;
            r_mem_addr   <= 32'd0;
            r_mem_wen    <= 1'b0;
            r_mem_wdata  <= 32'd0;
            r_mem_wbmask <= 4'd0;
            r_ifu_rdata  <= 32'd0;
            r_ifu_err    <= 1'b0;
            r_lsu_rdata  <= 32'd0;
            r_lsu_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_any) begin
                        r_owner      <= w_grant_lsu;
                        r_last_grant <= w_grant_lsu;
                        r_abort      <= 1'b0;
                        if (w_grant_lsu) begin
                            r_mem_addr   <= lsu_addr;
                            r_mem_wen    <= lsu_wen;
                            r_mem_wdata  <= lsu_wdata;
                            r_mem_wbmask <= lsu_wbmask;
                        end else begin
                            r_mem_addr   <= ifu_addr;
                            r_mem_wen    <= 1'b0;
                            r_mem_wdata  <= 32'd0;
                            r_mem_wbmask <= 4'd0;
                        end
                    end
                end
                c_ST_ISSUE: r_cnt <= '0;
                c_ST_WAIT: begin
                    if (w_wait_done) begin
                        if (r_owner == c_OWN_LSU) begin
                            r_lsu_rdata <= w_resp_data;
                            r_lsu_err   <= w_resp_err;
                        end else begin
                            r_ifu_rdata <= w_resp_data;
                            r_ifu_err   <= w_resp_err;
                        end
                        r_abort <= w_resp_err;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // The late RAM answer to an aborted request is swallowed here.
                c_ST_DRAIN: if (mem_respValid) r_abort <= 1'b0;
                default: ;
            endcase
        end
    end

    assign mem_reqValid  = (r_state == c_ST_ISSUE);
    assign mem_wen       = r_mem_wen;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wbmask    = r_mem_wbmask;
    assign mem_addr      = r_mem_addr;
    assign ifu_respValid = (r_state == c_ST_RESP) && (r_owner == c_OWN_IFU);
    assign lsu_respValid = (r_state == c_ST_RESP) && (r_owner == c_OWN_LSU);
    assign ifu_rdata     = r_ifu_rdata;
    assign ifu_err       = r_ifu_err;
    assign lsu_rdata     = r_lsu_rdata;
    assign lsu_err       = r_lsu_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with RAM model and scoreboard.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int TIMEOUT = 64;
    localparam int TO_W    = 7;

    logic        clock;
    logic        reset_n;
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        ifu_err;
    logic        lsu_reqValid;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wbmask;
    logic [31:0] lsu_addr;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        mem_reqValid;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wbmask;
    logic [31:0] mem_addr;
    logic        mem_respValid;
    logic [31:0] mem_rdata;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
        .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_reqValid(lsu_reqValid), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wbmask(lsu_wbmask), .lsu_addr(lsu_addr),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_reqValid(mem_reqValid), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wbmask(mem_wbmask), .mem_addr(mem_addr),
        .mem_respValid(mem_respValid), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          issue_cyc;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus-owned knobs read by the RAM model
    int          busy_cycles = 1;
    bit          rand_lat    = 1'b0;
    bit          ram_silent  = 1'b0;
    bit          use_fixed   = 1'b0;
    logic [31:0] fixed_data  = 32'd0;
    int          late_req    = 0;
    logic [31:0] late_data   = 32'd0;
    bit          log_en      = 1'b0;

    // Monitor-owned state
    exp_t        sb[$];
    logic        owner_log[$];
    int          cyc            = 0;
    int          issue_cnt      = 0;
    int          late_done      = 0;
    int          late_cyc       = -1;
    int          last_issue_cyc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RAM model + issue checker at posedge+1, response checker at negedge
    initial begin : monitor
        exp_t        e;
        logic        own;
        int          lat;
        int          ram_cnt;
        logic [31:0] ram_data;
        logic        prev_req;
        logic        busy;
        logic        model_last;
        logic [31:0] last_ifu_rdata;
        logic [31:0] last_lsu_rdata;
        ram_cnt = 0; ram_data = 32'd0; prev_req = 1'b0; busy = 1'b0; model_last = 1'b1;
        last_ifu_rdata = 32'd0; last_lsu_rdata = 32'd0;
        mem_respValid = 1'b0;
        mem_rdata     = 32'd0;
        forever begin
            @(posedge clock); #1;
            cyc++;
            if (!reset_n) begin
                mem_respValid = 1'b0; ram_cnt = 0; prev_req = 1'b0; busy = 1'b0;
                model_last = 1'b1; sb.delete(); last_ifu_rdata = 32'd0; last_lsu_rdata = 32'd0;
            end else begin
                mem_respValid = 1'b0;
                if (late_req != late_done) begin
                    mem_respValid = 1'b1; mem_rdata = late_data;
                    late_done = late_req; late_cyc = cyc;
                end else if (ram_cnt > 0) begin
                    ram_cnt--;
                    if (ram_cnt == 0) begin
                        mem_respValid = 1'b1; mem_rdata = ram_data;
                    end
                end
                if (mem_reqValid) begin
                    check("req_single_pulse", prev_req, 0);
                    check("req_while_busy", busy, 0);
                    check("req_has_requester", ifu_reqValid || lsu_reqValid, 1);
                    own = (ifu_reqValid && lsu_reqValid) ? ~model_last : lsu_reqValid;
                    model_last = own;
                    if (log_en) owner_log.push_back(own);
                    check("mem_addr",   mem_addr,   own ? lsu_addr : ifu_addr);
                    check("mem_wen",    mem_wen,    own ? lsu_wen : 1'b0);
                    check("mem_wdata",  mem_wdata,  own ? lsu_wdata : 32'd0);
                    check("mem_wbmask", mem_wbmask, own ? lsu_wbmask : 4'd0);
                    lat      = rand_lat ? int'($urandom_range(1, 4)) : busy_cycles;
                    ram_data = use_fixed ? fixed_data : $urandom;
                    if (own && lsu_wen) ram_data = 32'd0;
                    e.owner     = own;
                    e.err       = ram_silent;
                    e.rdata     = ram_silent ? 32'd0 : ram_data;
                    e.lat       = ram_silent ? TIMEOUT + 1 : lat + 2;
                    e.issue_cyc = cyc;
                    sb.push_back(e);
                    busy = 1'b1;
                    issue_cnt++;
                    last_issue_cyc = cyc;
                    if (!ram_silent) ram_cnt = lat + 1;
                end
                prev_req = mem_reqValid;
            end
            @(negedge clock);
            if (reset_n && (ifu_respValid || lsu_respValid)) begin
                check("resp_onehot", ifu_respValid && lsu_respValid, 0);
                if (sb.size() == 0) begin
                    check("resp_unexpected", {ifu_respValid, lsu_respValid}, 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_owner", lsu_respValid, e.owner);
                    check("resp_latency", cyc - e.issue_cyc, e.lat);
                    if (e.owner) begin
                        check("lsu_rdata", lsu_rdata, e.rdata);
                        check("lsu_err", lsu_err, e.err);
                        check("ifu_rdata_hold", ifu_rdata, last_ifu_rdata);
                        last_lsu_rdata = e.rdata;
                    end else begin
                        check("ifu_rdata", ifu_rdata, e.rdata);
                        check("ifu_err", ifu_err, e.err);
                        check("lsu_rdata_hold", lsu_rdata, last_lsu_rdata);
                        last_ifu_rdata = e.rdata;
                    end
                end
                busy = 1'b0;
            end
        end
    end

    task automatic ifu_do(input logic [31:0] addr);
        int w;
        ifu_reqValid = 1'b1;
        ifu_addr     = addr;
        w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (!ifu_respValid && w < 300);
        check("ifu_resp_seen", ifu_respValid, 1);
        ifu_reqValid = 1'b0;
    endtask

    task automatic lsu_do(input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask);
        int w;
        lsu_reqValid = 1'b1;
        lsu_wen      = wen;
        lsu_addr     = addr;
        lsu_wdata    = wdata;
        lsu_wbmask   = mask;
        w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (!lsu_respValid && w < 300);
        check("lsu_resp_seen", lsu_respValid, 1);
        lsu_reqValid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_reqValid"}, mem_reqValid, 0);
        check({tag, "_mem_addr"},     mem_addr, 0);
        check({tag, "_mem_wen"},      mem_wen, 0);
        check({tag, "_mem_wdata"},    mem_wdata, 0);
        check({tag, "_mem_wbmask"},   mem_wbmask, 0);
        check({tag, "_respValid"},    {ifu_respValid, lsu_respValid}, 0);
        check({tag, "_ifu_rdata"},    ifu_rdata, 0);
        check({tag, "_lsu_rdata"},    lsu_rdata, 0);
        check({tag, "_err"},          {ifu_err, lsu_err}, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base;
        int w;
        reset_n = 1'b0;
        ifu_reqValid = 1'b0; ifu_addr = 32'd0;
        lsu_reqValid = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'd0;
        lsu_wdata = 32'd0; lsu_wbmask = 4'd0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Single IFU read, one busy cycle
        busy_cycles = 1; use_fixed = 1'b1; fixed_data = 32'hDEADBEEF;
        ifu_do(32'h100);
        use_fixed = 1'b0;

        // Tie right after reset: IFU, LSU, IFU, LSU
        do_reset();
        log_en = 1'b1; busy_cycles = 2;
        fork
            begin ifu_do(32'h200); ifu_do(32'h204); end
            begin lsu_do(1'b0, 32'h400, 32'h0, 4'h0); lsu_do(1'b0, 32'h404, 32'h0, 4'h0); end
        join
        log_en = 1'b0;
        check("rr_count", owner_log.size(), 4);
        if (owner_log.size() == 4) begin
            check("rr_0", owner_log[0], 0);
            check("rr_1", owner_log[1], 1);
            check("rr_2", owner_log[2], 0);
            check("rr_3", owner_log[3], 1);
        end

        // LSU write
        @(negedge clock);
        lsu_do(1'b1, 32'h20, 32'h12345678, 4'b0011);

        // Timeout, late response dropped in DRAIN, next request served
        @(negedge clock);
        ram_silent = 1'b1;
        ifu_do(32'h40);
        use_fixed = 1'b1; fixed_data = 32'hCAFEF00D; busy_cycles = 1;
        fork
            lsu_do(1'b0, 32'h44, 32'h0, 4'h0);
            begin
                repeat (8) @(negedge clock);
                ram_silent = 1'b0;
                late_data  = 32'hBAD0BAD0;
                late_req++;
            end
        join
        check("grant_after_drain", last_issue_cyc > late_cyc, 1);
        check("ifu_err_hold", ifu_err, 1);
        use_fixed = 1'b0;

        // Asynchronous reset while in WAIT
        @(negedge clock);
        busy_cycles = 4;
        base = issue_cnt;
        ifu_reqValid = 1'b1; ifu_addr = 32'h300;
        w = 0;
        while (issue_cnt == base && w < 20) begin
            @(negedge clock);
            w++;
        end
        check("rst_test_issue", issue_cnt, base + 1);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_rst");
        ifu_reqValid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        busy_cycles = 2;
        ifu_do(32'h304);

        // Random back-to-back traffic
        rand_lat = 1'b1;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clock);
                    ifu_do(32'($urandom_range(0, 255)) << 2);
                end
            end
            begin
                for (int j = 0; j < 25; j++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clock);
                    lsu_do(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                           $urandom, 4'($urandom_range(0, 15)));
                end
            end
        join
        repeat (4) @(negedge clock);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles in WAIT before the transaction is aborted.
REQ-002 Parameter TO_W, default 7: width of the timeout counter; SHALL satisfy 2^TO_W > TIMEOUT.
REQ-003 clock  in  1  single clock; all state changes on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ifu_reqValid, ifu_addr[31:0]  in  instruction-fetch read request; held stable until ifu_respValid.
REQ-006 ifu_respValid  out  1; ifu_rdata  out  32: fetch response.
REQ-007 lsu_reqValid, lsu_wen, lsu_wdata[31:0], lsu_wbmask[3:0], lsu_addr[31:0]  in  load/store request; held stable until lsu_respValid.
REQ-008 lsu_respValid, lsu_err  out  1; lsu_rdata  out  32: load/store response.
REQ-009 ifu_err  out  1: fetch aborted by timeout.
REQ-010 mem_reqValid, mem_wen, mem_wdata[31:0], mem_wbmask[3:0], mem_addr[31:0]  out: request to the shared RAM port.
REQ-011 mem_respValid  in  1; mem_rdata  in  32: RAM response.

Function
REQ-012 States: IDLE, ISSUE, WAIT, RESP, DRAIN; one-hot or binary at implementer's choice.
REQ-013 IDLE: if exactly one reqValid is high, grant it; if both are high, grant the requester not granted last (round-robin); if neither, stay in IDLE.
REQ-014 On grant, latch owner, addr, wen, wdata, wbmask (IFU: wen=0, wbmask=0, wdata=0); go to ISSUE; update last_grant.
REQ-015 ISSUE: mem_reqValid=1 for exactly this one cycle with the latched fields; go to WAIT; clear the timeout counter.
REQ-016 mem_reqValid SHALL be 0 in every state except ISSUE; the mem_* fields SHALL hold their latched values from ISSUE until the next grant.
REQ-017 WAIT: on mem_respValid, register mem_rdata into the owner's rdata, set err=0 and go to RESP; otherwise increment the counter.
REQ-018 WAIT: when the counter reaches TIMEOUT without mem_respValid, set owner rdata=0 and err=1, and go to RESP with an abort flag set.
REQ-019 RESP: owner respValid=1 for exactly one cycle, non-owner respValid=0; go to DRAIN if the abort flag is set, else IDLE.
REQ-020 reqValid from either requester SHALL be ignored in ISSUE, WAIT, RESP and DRAIN.
REQ-021 A reqValid still high in the cycle after RESP counts as a new request.
REQ-022 DRAIN: discard mem_respValid/mem_rdata; go to IDLE on mem_respValid; no new grant until then.
REQ-023 mem_respValid in IDLE, ISSUE or RESP SHALL be ignored.
REQ-024 Minimum grant-to-response latency: request seen in IDLE at cycle N -> mem_reqValid in N+1 -> owner respValid no earlier than N+4 (RAM response at N+3).
REQ-025 For a write, rdata SHALL carry mem_rdata as returned (0 from the RAM).
REQ-026 ifu_rdata and lsu_rdata SHALL hold their last value until overwritten by their own RESP.
REQ-027 With both requesters held high continuously, grants SHALL strictly alternate; neither requester waits more than one foreign transaction.

Reset
REQ-028 reset_n low SHALL asynchronously force state=IDLE, last_grant=LSU (first tie goes to IFU), counter=0, abort flag=0, and all outputs (mem_*, *_respValid, *_rdata, *_err) to 0.
REQ-029 Reset asserted mid-transaction SHALL abandon it without a response; the first grant after reset_n deasserts occurs no earlier than the first clock edge after release.

Verification
REQ-030 IFU-only read addr 0x100, RAM returns 0xDEADBEEF after one cycle busy -> single mem_reqValid pulse, ifu_respValid one cycle with ifu_rdata=0xDEADBEEF, ifu_err=0.
REQ-031 Both requesters assert in the same cycle after reset -> IFU granted first, then LSU, alternating for 4 transactions (IFU, LSU, IFU, LSU).
REQ-032 LSU write addr 0x20, wdata 0x12345678, wbmask 4'b0011 -> mem_wen=1 and fields match for one cycle; lsu_respValid=1, lsu_rdata=0.
REQ-033 RAM never responds, TIMEOUT=64 -> owner respValid after 64 WAIT cycles with err=1 and rdata=0; a late mem_respValid is dropped in DRAIN; the next request is served normally.
REQ-034 reset_n pulsed low during WAIT -> all outputs 0 immediately, no respValid, a subsequent IFU request completes normally.
REQ-035 Random back-to-back traffic with scoreboard -> every request gets exactly one response with the correct data; mem_reqValid is never high outside ISSUE.
